tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences TLBR/TLBWI/TLBWR/TLBP between the commit stage, the TLB entry array and the CP0 register file.
//  Takes one op at a time with a valid/ready handshake and drives the array's 1-cycle-latency read port and its write port.
//  Finishes each op with single-cycle tlbr/tlbwr/tlbp pulses into CP0. TLBP is a sequential scan: one entry compared per cycle.
// PARAMETERS
//  TLB_IDXBITS  5   index width; TLB_ENTRIES = 2**TLB_IDXBITS (32), fixed in common.vh
// PORTS
//  clk          in   1   clock
//  resetn       in   1   asynchronous active-low reset
//  req_valid    in   1   op request from commit stage
//  req_op       in   2   0=TLBR 1=TLBWI 2=TLBWR 3=TLBP
//  req_ready    out  1   high only in IDLE
//  op_done      out  1   1-cycle pulse: all side effects of the op are complete
//  cp0_index    in   32  CP0 Index (bits IDXBITS-1:0 used)
//  cp0_random   in   32  CP0 Random
//  cp0_entryhi  in   32  VPN2[31:13], ASID[7:0]
//  cp0_entrylo0 in   32  PFN[25:6] C[5:3] D V G
//  cp0_entrylo1 in   32  same layout as entrylo0
//  cp0_mask     in   12  PageMask mask field
//  tlb_raddr    out  IDX array read address; data valid the next cycle
//  tlb_rdata    in   90  packed entry (layout in common.vh)
//  tlb_we       out  1   array write strobe
//  tlb_waddr    out  IDX array write address
//  tlb_wdata    out  90  packed entry
//  tlbr         out  1   pulse; tlbr_lo0/lo1/hi/mask valid with it
//  tlbr_lo0     out  32  {6'd0,pfn0,c0,d0,v0,g}
//  tlbr_lo1     out  32  {6'd0,pfn1,c1,d1,v1,g}
//  tlbr_hi      out  32  {vpn2,5'd0,asid}
//  tlbr_mask    out  12  entry mask
//  tlbwr        out  1   pulse; CP0 advances Random
//  tlbp         out  1   pulse; tlbp_index valid with it
//  tlbp_index   out  32  hit: {1'b0,..,idx}; miss: 32'h8000_0000
// BEHAVIOUR
//  Reset: state IDLE, probe counter 0; all pulses, tlb_we and every data output 0; req_ready 1.
//  Accept on req_valid&&req_ready (cycle t). Latch op and all cp0_* operands; later cp0 changes are ignored.
//  FSM: IDLE -> RD_ISSUE -> RD_DATA -> IDLE (TLBR)
//       IDLE -> WRITE -> IDLE (TLBWI/TLBWR)
//       IDLE -> PROBE -> IDLE (TLBP)
//  TLBR:
//   - t+1: raddr = index[IDX-1:0].
//   - t+2: tlbr=1, op_done=1; fields unpacked from tlb_rdata.
//  TLBWI/TLBWR:
//   - t+1: tlb_we=1, op_done=1; tlbwr=1 for TLBWR only.
//   - waddr = latched index (TLBWI) or latched random (TLBWR).
//   - wdata: vpn2=hi[31:13], asid=hi[7:0], g=lo0.G&lo1.G, mask, pfn/c/d/v from lo0 and lo1.
//  TLBP:
//   - Counter i runs 0..N-1; raddr=i at cycle t+1+i; compare rdata for entry i at t+2+i.
//   - Match: (vpn2 & ~{7'd0,mask})==(hi.vpn2 & ~{7'd0,mask}) && (g || asid==hi.asid), using the entry's mask.
//   - First (lowest) hit ends the scan: tlbp=1, op_done=1, tlbp_index=i at t+2+i.
//   - No hit: miss result at t+N+1, no wrap.
//   - Issue reads beyond the hit are harmless.
//  Every op: exactly one op_done. Pulses last one cycle, and only the pulse for the op's type fires.
//  req_ready stays 0 from t+1 until the cycle after op_done, so back-to-back ops are spaced by a cycle in IDLE.
//  A read is never issued in the same cycle as a write.
//  Reset asserted mid-op: immediate IDLE with no pulse; a write already strobed is not undone.
// STRUCTURE
//  common.vh: TLB_IDXBITS, TLB_ENTRIES, op encodings, packed-entry field ranges (TLBE_VPN2, TLBE_ASID, TLBE_G,
//   TLBE_MASK, TLBE_PFN0.., 90 bits total), EXC/ENTRYLO ranges already there.
//  Sub-module tlb_entry_match: combinational (entry, vpn2, asid) -> hit. Reused later by the I/D translation lookups.
// TESTING
//  TLBWI: index=5, hi=32'h0040_2012, lo0=32'h0000_1016, lo1=32'h0000_1056 -> t+1: we=1 waddr=5 g=0, op_done; no tlbwr.
//  TLBR of that entry -> t+2: tlbr=1, hi=32'h0040_2012, lo0=32'h0000_1016, lo1=32'h0000_1056.
//  TLBP with matching hi -> tlbp_index=5 at t+7.
//   - Change ASID to 8'h13 -> miss 32'h8000_0000 at t+33.
//   - Set entry g=1 -> hit 5.
//  TLBWR with random=31 -> waddr=31, tlbwr=1, op_done at t+1.
//  Two entries (3 and 9) matching with mask=12'hfff, VPN2 differing in low 12 bits -> tlbp_index=3.
//  Reset at t+4 of TLBP -> no tlbp/op_done; req_ready=1 once reset deasserts.

Source files
------------

// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types for the TLB op sequencer: op codes, FSM states,
// packed TLB entry layout and CP0 EntryLo formatting helper.
package tlb_op_ctrl_pkg;

  localparam int TLB_IDXBITS = 5;
  localparam int TLB_ENTRIES = 1 << TLB_IDXBITS;
  localparam int TLBE_W      = 90;

  localparam logic [31:0] TLBP_MISS = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_TLBR  = 2'd0,
    OP_TLBWI = 2'd1,
    OP_TLBWR = 2'd2,
    OP_TLBP  = 2'd3
  } tlb_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_DATA,
    S_WRITE,
    S_PROBE
  } tlb_state_e;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [11:0] mask;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic logic [31:0] lo_word(
    input logic [19:0] pfn,
    input logic [2:0]  c,
    input logic        d,
    input logic        v,
    input logic        g
  );
    return {6'd0, pfn, c, d, v, g};
  endfunction

endpackage

// File: rtl/tlb_entry_match.sv
// Combinational VPN2/ASID compare of one TLB entry, honouring the
// entry's page mask and global bit. Ports: entry_i, vpn2_i, asid_i -> hit_o.
module tlb_entry_match
  import tlb_op_ctrl_pkg::*;
(
  input  tlb_entry_t  entry_i,
  input  logic [18:0] vpn2_i,
  input  logic [7:0]  asid_i,
  output logic        hit_o
);

  logic [18:0] vmask;
  logic        vpn_eq;
  logic        asid_ok;

  // mask bits set mean "don't compare" for the low VPN2 bits
  assign vmask   = ~{7'd0, entry_i.mask};
  assign vpn_eq  = (entry_i.vpn2 & vmask) == (vpn2_i & vmask);
  assign asid_ok = entry_i.g || (entry_i.asid == asid_i);
  assign hit_o   = vpn_eq && asid_ok;

  logic unused_pfn;
  assign unused_pfn = ^{entry_i.pfn0, entry_i.c0, entry_i.d0,
                        entry_i.v0, entry_i.pfn1, entry_i.c1,
                        entry_i.d1, entry_i.v1};

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBR/TLBWI/TLBWR/TLBP between commit, the TLB array and CP0.
// Ports: req handshake, cp0_* operands, array rd/wr port, CP0 result pulses.
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   req_valid,
  input  logic [1:0]             req_op,
  output logic                   req_ready,
  output logic                   op_done,
  input  logic [31:0]            cp0_index,
  input  logic [31:0]            cp0_random,
  input  logic [31:0]            cp0_entryhi,
  input  logic [31:0]            cp0_entrylo0,
  input  logic [31:0]            cp0_entrylo1,
  input  logic [11:0]            cp0_mask,
  output logic [TLB_IDXBITS-1:0] tlb_raddr,
  input  logic [TLBE_W-1:0]      tlb_rdata,
  output logic                   tlb_we,
  output logic [TLB_IDXBITS-1:0] tlb_waddr,
  output logic [TLBE_W-1:0]      tlb_wdata,
  output logic                   tlbr,
  output logic [31:0]            tlbr_lo0,
  output logic [31:0]            tlbr_lo1,
  output logic [31:0]            tlbr_hi,
  output logic [11:0]            tlbr_mask,
  output logic                   tlbwr,
  output logic                   tlbp,
  output logic [31:0]            tlbp_index
);

  localparam logic [TLB_IDXBITS-1:0] LAST_IDX = '1;

  tlb_state_e             state_q;
  logic [TLB_IDXBITS-1:0] raddr_q;
  logic [TLB_IDXBITS-1:0] cnt_q;
  logic                   pvld_q;
  logic [18:0]            pvpn2_q;
  logic [7:0]             pasid_q;
  logic                   we_q;
  logic                   tlbwr_q;
  logic [TLB_IDXBITS-1:0] waddr_q;
  tlb_entry_t             wdata_q;

  tlb_entry_t rent;
  tlb_entry_t wr_ent;
  logic       hit;
  logic       rd_fire;
  logic       probe_end;

  assign rent = tlb_entry_t'(tlb_rdata);

  tlb_entry_match u_match (
    .entry_i (rent),
    .vpn2_i  (pvpn2_q),
    .asid_i  (pasid_q),
    .hit_o   (hit)
  );

  always_comb begin
    wr_ent      = '0;
    wr_ent.vpn2 = cp0_entryhi[31:13];
    wr_ent.asid = cp0_entryhi[7:0];
    wr_ent.g    = cp0_entrylo0[0] & cp0_entrylo1[0];
    wr_ent.mask = cp0_mask;
    wr_ent.pfn0 = cp0_entrylo0[25:6];
    wr_ent.c0   = cp0_entrylo0[5:3];
    wr_ent.d0   = cp0_entrylo0[2];
    wr_ent.v0   = cp0_entrylo0[1];
    wr_ent.pfn1 = cp0_entrylo1[25:6];
    wr_ent.c1   = cp0_entrylo1[5:3];
    wr_ent.d1   = cp0_entrylo1[2];
    wr_ent.v1   = cp0_entrylo1[1];
  end

  // pvld_q marks that rdata now holds entry cnt_q
  assign rd_fire   = state_q == S_RD_DATA;
  assign probe_end = (state_q == S_PROBE) && pvld_q &&
                     (hit || cnt_q == LAST_IDX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      cnt_q   <= '0;
      pvld_q  <= 1'b0;
      pvpn2_q <= '0;
      pasid_q <= '0;
      we_q    <= 1'b0;
      tlbwr_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            pvpn2_q <= cp0_entryhi[31:13];
            pasid_q <= cp0_entryhi[7:0];
            unique case (tlb_op_e'(req_op))
              OP_TLBR: begin
                state_q <= S_RD_ISSUE;
                raddr_q <= cp0_index[TLB_IDXBITS-1:0];
              end
              OP_TLBWI: begin
                state_q <= S_WRITE;
                we_q    <= 1'b1;
                waddr_q <= cp0_index[TLB_IDXBITS-1:0];
                wdata_q <= wr_ent;
              end
              OP_TLBWR: begin
                state_q <= S_WRITE;
                we_q    <= 1'b1;
                tlbwr_q <= 1'b1;
                waddr_q <= cp0_random[TLB_IDXBITS-1:0];
                wdata_q <= wr_ent;
              end
              OP_TLBP: begin
                state_q <= S_PROBE;
                raddr_q <= '0;
                cnt_q   <= '0;
                pvld_q  <= 1'b0;
              end
            endcase
          end
        end
        S_RD_ISSUE: state_q <= S_RD_DATA;
        S_RD_DATA:  state_q <= S_IDLE;
        S_WRITE: begin
          state_q <= S_IDLE;
          we_q    <= 1'b0;
          tlbwr_q <= 1'b0;
        end
        S_PROBE: begin
          if (!pvld_q) begin
            pvld_q  <= 1'b1;
            raddr_q <= raddr_q + 1'b1;
          end else if (hit || cnt_q == LAST_IDX) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            // hold at the top entry rather than wrap
            if (raddr_q != LAST_IDX) raddr_q <= raddr_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = state_q == S_IDLE;
  assign op_done   = rd_fire | probe_end | (state_q == S_WRITE);
  assign tlb_raddr = raddr_q;
  assign tlb_we    = we_q;
  assign tlb_waddr = waddr_q;
  assign tlb_wdata = wdata_q;
  assign tlbwr     = tlbwr_q;
  assign tlbr      = rd_fire;
  assign tlbp      = probe_end;

  // data outputs stay 0 outside their pulse
  assign tlbr_lo0  = rd_fire ?
    lo_word(rent.pfn0, rent.c0, rent.d0, rent.v0, rent.g) : '0;
  assign tlbr_lo1  = rd_fire ?
    lo_word(rent.pfn1, rent.c1, rent.d1, rent.v1, rent.g) : '0;
  assign tlbr_hi   = rd_fire ? {rent.vpn2, 5'd0, rent.asid} : '0;
  assign tlbr_mask = rd_fire ? rent.mask : '0;
  assign tlbp_index = !probe_end ? '0 :
                      hit ? {{(32-TLB_IDXBITS){1'b0}}, cnt_q} :
                      TLBP_MISS;

  logic unused_cp0;
  assign unused_cp0 = ^{cp0_index[31:TLB_IDXBITS],
                        cp0_random[31:TLB_IDXBITS],
                        cp0_entryhi[12:8],
                        cp0_entrylo0[31:26],
                        cp0_entrylo1[31:26]};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed-vector bench for tlb_op_ctrl with a small behavioural
// TLB array (1-cycle read latency) attached to the array ports.
module tb_tlb_op_ctrl;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_op = '0;
  logic        req_ready;
  logic        op_done;
  logic [31:0] cp0_index = '0;
  logic [31:0] cp0_random = '0;
  logic [31:0] cp0_entryhi = '0;
  logic [31:0] cp0_entrylo0 = '0;
  logic [31:0] cp0_entrylo1 = '0;
  logic [11:0] cp0_mask = '0;
  logic [4:0]  tlb_raddr;
  logic [89:0] tlb_rdata = '0;
  logic        tlb_we;
  logic [4:0]  tlb_waddr;
  logic [89:0] tlb_wdata;
  logic        tlbr;
  logic [31:0] tlbr_lo0;
  logic [31:0] tlbr_lo1;
  logic [31:0] tlbr_hi;
  logic [11:0] tlbr_mask;
  logic        tlbwr;
  logic        tlbp;
  logic [31:0] tlbp_index;

  always #5 clk = ~clk;

  tlb_op_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_ready    (req_ready),
    .op_done      (op_done),
    .cp0_index    (cp0_index),
    .cp0_random   (cp0_random),
    .cp0_entryhi  (cp0_entryhi),
    .cp0_entrylo0 (cp0_entrylo0),
    .cp0_entrylo1 (cp0_entrylo1),
    .cp0_mask     (cp0_mask),
    .tlb_raddr    (tlb_raddr),
    .tlb_rdata    (tlb_rdata),
    .tlb_we       (tlb_we),
    .tlb_waddr    (tlb_waddr),
    .tlb_wdata    (tlb_wdata),
    .tlbr         (tlbr),
    .tlbr_lo0     (tlbr_lo0),
    .tlbr_lo1     (tlbr_lo1),
    .tlbr_hi      (tlbr_hi),
    .tlbr_mask    (tlbr_mask),
    .tlbwr        (tlbwr),
    .tlbp         (tlbp),
    .tlbp_index   (tlbp_index)
  );

  logic [89:0] mem [32];

  initial for (int i = 0; i < 32; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (tlb_we) mem[tlb_waddr] <= tlb_wdata;
    tlb_rdata <= mem[tlb_raddr];
  end

  localparam logic [1:0] TLBR  = 2'd0;
  localparam logic [1:0] TLBWI = 2'd1;
  localparam logic [1:0] TLBWR = 2'd2;
  localparam logic [1:0] TLBP  = 2'd3;

  // hand-packed entries: vpn2,asid,g,mask,pfn0,c0,d0,v0,pfn1,c1,d1,v1
  localparam logic [89:0] E5 = {19'h201, 8'h12, 1'b0, 12'h000,
    20'h40, 3'd2, 1'b1, 1'b1, 20'h41, 3'd2, 1'b1, 1'b1};
  localparam logic [89:0] E31 = {19'h2, 8'h01, 1'b0, 12'h000,
    20'h1, 3'd0, 1'b0, 1'b0, 20'h2, 3'd0, 1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [89:0] got,
                     input logic [89:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] idx,
                       input logic [31:0] rnd, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1,
                       input logic [11:0] msk);
    int w;
    w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    req_op       = op;
    cp0_index    = idx;
    cp0_random   = rnd;
    cp0_entryhi  = hi;
    cp0_entrylo0 = lo0;
    cp0_entrylo1 = lo1;
    cp0_mask     = msk;
    req_valid    = 1'b1;
    @(posedge clk);
    #1;
    req_valid    = 1'b0;
    cp0_index    = ~idx;
    cp0_random   = ~rnd;
    cp0_entryhi  = ~hi;
    cp0_entrylo0 = ~lo0;
    cp0_entrylo1 = ~lo1;
    cp0_mask     = ~msk;
  endtask

  task automatic wait_done(input string tag, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!op_done && k < 40);
    chk(tag, 90'(op_done), 90'(1));
  endtask

  int k;
  logic seen;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 90'(req_ready), 90'(1));
    chk("rst_done", 90'(op_done), 90'(0));
    chk("rst_we", 90'(tlb_we), 90'(0));
    chk("rst_raddr", 90'(tlb_raddr), 90'(0));
    chk("rst_waddr", 90'(tlb_waddr), 90'(0));
    chk("rst_wdata", tlb_wdata, 90'(0));
    chk("rst_pulses", 90'({tlbr, tlbwr, tlbp}), 90'(0));
    chk("rst_data", 90'({tlbr_lo0, tlbr_hi, tlbp_index}), 90'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_ready2", 90'(req_ready), 90'(1));

    issue(TLBWI, 5, 0, 32'h0040_2012, 32'h0000_1016, 32'h0000_1056, 0);
    @(negedge clk);
    chk("wi_we", 90'(tlb_we), 90'(1));
    chk("wi_waddr", 90'(tlb_waddr), 90'(5));
    chk("wi_wdata", tlb_wdata, E5);
    chk("wi_done", 90'(op_done), 90'(1));
    chk("wi_pulses", 90'({tlbr, tlbwr, tlbp}), 90'(0));
    chk("wi_ready", 90'(req_ready), 90'(0));
    @(negedge clk);
    chk("wi_we_end", 90'({tlb_we, op_done}), 90'(0));
    chk("wi_ready2", 90'(req_ready), 90'(1));

    issue(TLBR, 5, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("r_raddr", 90'(tlb_raddr), 90'(5));
    chk("r_early", 90'({tlbr, op_done}), 90'(0));
    @(negedge clk);
    chk("r_pulse", 90'({tlbr, op_done, tlbwr, tlbp}), 90'(4'b1100));
    chk("r_hi", 90'(tlbr_hi), 90'(32'h0040_2012));
    chk("r_lo0", 90'(tlbr_lo0), 90'(32'h0000_1016));
    chk("r_lo1", 90'(tlbr_lo1), 90'(32'h0000_1056));
    chk("r_mask", 90'(tlbr_mask), 90'(0));

    issue(TLBP, 0, 0, 32'h0040_2012, 0, 0, 0);
    wait_done("p_done", k);
    chk("p_cycle", 90'(k), 90'(7));
    chk("p_pulse", 90'({tlbp, tlbr, tlbwr}), 90'(3'b100));
    chk("p_index", 90'(tlbp_index), 90'(5));

    issue(TLBP, 0, 0, 32'h0040_2013, 0, 0, 0);
    wait_done("pm_done", k);
    chk("pm_cycle", 90'(k), 90'(33));
    chk("pm_index", 90'(tlbp_index), 90'(32'h8000_0000));

    issue(TLBWI, 5, 0, 32'h0040_2012, 32'h0000_1017, 32'h0000_1057, 0);
    @(negedge clk);
    chk("wig_g", 90'(tlb_wdata[62]), 90'(1));
    issue(TLBP, 0, 0, 32'h0040_2013, 0, 0, 0);
    wait_done("pg_done", k);
    chk("pg_cycle", 90'(k), 90'(7));
    chk("pg_index", 90'(tlbp_index), 90'(5));

    issue(TLBWR, 5, 31, 32'h0000_4001, 32'h0000_0041, 32'h0000_0080, 0);
    @(negedge clk);
    chk("wr_waddr", 90'(tlb_waddr), 90'(31));
    chk("wr_pulse", 90'({tlb_we, tlbwr, op_done, tlbr, tlbp}),
        90'(5'b11100));
    chk("wr_wdata", tlb_wdata, E31);
    @(negedge clk);
    chk("wr_end", 90'({tlbwr, tlb_we, op_done}), 90'(0));

    issue(TLBWI, 3, 0, 32'h0060_0022, 0, 0, 12'hfff);
    @(negedge clk);
    issue(TLBWI, 9, 0, 32'h007F_E022, 0, 0, 12'hfff);
    @(negedge clk);
    issue(TLBP, 0, 0, 32'h0015_6022, 0, 0, 0);
    wait_done("pl_done", k);
    chk("pl_cycle", 90'(k), 90'(5));
    chk("pl_index", 90'(tlbp_index), 90'(3));

    issue(TLBR, 9, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("r9_tlbr", 90'(tlbr), 90'(1));
    chk("r9_hi", 90'(tlbr_hi), 90'(32'h007F_E022));
    chk("r9_mask", 90'(tlbr_mask), 90'(12'hfff));

    issue(TLBP, 0, 0, 32'h0000_0099, 0, 0, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | op_done | tlbp;
    end
    @(negedge clk);
    resetn = 1'b0;
    #1;
    seen = seen | op_done | tlbp;
    @(posedge clk);
    @(negedge clk);
    seen = seen | op_done | tlbp;
    resetn = 1'b1;
    #1;
    chk("mr_ready", 90'(req_ready), 90'(1));
    repeat (40) begin
      @(negedge clk);
      seen = seen | op_done | tlbp;
    end
    chk("mr_no_done", 90'(seen), 90'(0));

    issue(TLBP, 0, 0, 32'h0040_2013, 0, 0, 0);
    wait_done("pa_done", k);
    chk("pa_cycle", 90'(k), 90'(7));
    chk("pa_index", 90'(tlbp_index), 90'(5));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
